sprite_draw_scheduler: RTL and testbench

SPRITE_DRAW_SCHEDULER -- requirements
Module: sprite_draw_scheduler

---
 rtl/draw_pkg.sv | 15 +
 rtl/pixel_sweep_counter.sv | 32 +++
 rtl/sprite_draw_scheduler.sv | 137 +++++++++++++
 tb/tb_sprite_draw_scheduler.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/draw_pkg.sv
// draw_pkg: shared screen geometry, sprite size and FSM state encoding for the sprite draw path.
// No ports; imported by pixel_sweep_counter and sprite_draw_scheduler.
package draw_pkg;
    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;
    localparam int SPR_DIM  = 4;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        SCAN,
        DRAW,
        DONE
    } state_t;
endpackage

// File: rtl/pixel_sweep_counter.sv
// pixel_sweep_counter: raster counter walking every screen pixel, x fastest.
// Ports: clk, reset (sync, active-high), clear (return to (0,0)), enable (advance one pixel),
//        x/y (current pixel), wrap (high while sitting on the last pixel of the screen).
module pixel_sweep_counter
    import draw_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    input  logic       enable,
    output logic [7:0] x,
    output logic [6:0] y,
    output logic       wrap
);
    logic x_end;
    logic y_end;

    assign x_end = x == 8'(SCREEN_W - 1);
    assign y_end = y == 7'(SCREEN_H - 1);
    assign wrap  = x_end && y_end;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            x <= '0;
            y <= '0;
        end else if (enable) begin
            x <= x_end ? '0 : x + 8'd1;
            if (x_end)
                y <= y_end ? '0 : y + 7'd1;
        end
    end
endmodule

// File: rtl/sprite_draw_scheduler.sv
// sprite_draw_scheduler: per frame, erases the screen then draws each enabled 4x4 sprite in index order.
// Ports: clk, reset (sync, active-high), frame_tick (start a frame), spr_en/spr_x/spr_y/spr_c (packed
//        per-sprite enable, position, colour), x/y/colour/plot (registered pixel-write port),
//        busy (frame in progress), frame_done (one-cycle completion pulse), overrun (sticky: tick while busy).
module sprite_draw_scheduler
    import draw_pkg::*;
#(
    parameter int         N_SPR     = 9,
    parameter logic [2:0] BG_COLOUR = 3'b000
)
(
    input  logic               clk,
    input  logic               reset,
    input  logic               frame_tick,
    input  logic [N_SPR-1:0]   spr_en,
    input  logic [8*N_SPR-1:0] spr_x,
    input  logic [7*N_SPR-1:0] spr_y,
    input  logic [3*N_SPR-1:0] spr_c,
    output logic [7:0]         x,
    output logic [6:0]         y,
    output logic [2:0]         colour,
    output logic               plot,
    output logic               busy,
    output logic               frame_done,
    output logic               overrun
);
    localparam int PW = $clog2(N_SPR + 1);

    state_t        state;
    logic [PW-1:0] ptr;
    logic [PW-1:0] sel;
    logic [7:0]    sx;
    logic [6:0]    sy;
    logic [2:0]    sc;
    logic [1:0]    dx;
    logic [1:0]    dy;
    logic [8:0]    px;
    logic [7:0]    py;
    logic [7:0]    cx;
    logic [6:0]    cy;
    logic          wrap;
    logic          last_dx;
    logic          last_dy;

    pixel_sweep_counter sweep (
        .clk    (clk),
        .reset  (reset),
        .clear  (state == IDLE),
        .enable (state == CLEAR),
        .x      (cx),
        .y      (cy),
        .wrap   (wrap)
    );

    // ptr reaches N_SPR as the end marker; keep the select in range for the input slices
    assign sel     = (ptr < PW'(N_SPR)) ? ptr : '0;
    // one bit wider than the coordinate so a sum past the edge is clipped rather than wrapped
    assign px      = {1'b0, sx} + {7'b0, dx};
    assign py      = {1'b0, sy} + {6'b0, dy};
    assign last_dx = dx == 2'(SPR_DIM - 1);
    assign last_dy = dy == 2'(SPR_DIM - 1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            ptr        <= '0;
            sx         <= '0;
            sy         <= '0;
            sc         <= '0;
            dx         <= '0;
            dy         <= '0;
            x          <= '0;
            y          <= '0;
            colour     <= '0;
            plot       <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            plot       <= 1'b0;
            frame_done <= 1'b0;
            if (frame_tick && state != IDLE)
                overrun <= 1'b1;
            case (state)
                IDLE: begin
                    if (frame_tick) begin
                        state <= CLEAR;
                        busy  <= 1'b1;
                    end
                end
                CLEAR: begin
                    x      <= cx;
                    y      <= cy;
                    colour <= BG_COLOUR;
                    plot   <= 1'b1;
                    if (wrap) begin
                        state <= SCAN;
                        ptr   <= '0;
                    end
                end
                SCAN: begin
                    if (ptr == PW'(N_SPR)) begin
                        state      <= DONE;
                        frame_done <= 1'b1;
                    end else if (spr_en[sel]) begin
                        sx    <= spr_x[int'(sel) * 8 +: 8];
                        sy    <= spr_y[int'(sel) * 7 +: 7];
                        sc    <= spr_c[int'(sel) * 3 +: 3];
                        dx    <= '0;
                        dy    <= '0;
                        state <= DRAW;
                    end else begin
                        ptr <= ptr + PW'(1);
                    end
                end
                DRAW: begin
                    x      <= px[7:0];
                    y      <= py[6:0];
                    colour <= sc;
                    plot   <= (px < 9'(SCREEN_W)) && (py < 8'(SCREEN_H));
                    dx     <= dx + 2'd1;
                    if (last_dx)
                        dy <= dy + 2'd1;
                    if (last_dx && last_dy) begin
                        ptr   <= ptr + PW'(1);
                        state <= SCAN;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sprite_draw_scheduler.sv
// tb_sprite_draw_scheduler: directed scenarios for sprite_draw_scheduler with hand-computed expectations.
module tb_sprite_draw_scheduler;
    localparam int N = 9;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           frame_tick = 1'b0;
    logic [N-1:0]   spr_en = '0;
    logic [8*N-1:0] spr_x = '0;
    logic [7*N-1:0] spr_y = '0;
    logic [3*N-1:0] spr_c = '0;
    logic [7:0]     x;
    logic [6:0]     y;
    logic [2:0]     colour;
    logic           plot;
    logic           busy;
    logic           frame_done;
    logic           overrun;

    int n_cmp = 0;
    int n_bad = 0;
    int px_q[$];
    int py_q[$];
    int pc_q[$];
    int pt_q[$];
    int done_cyc;
    int done_cnt;
    logic busy_after;
    logic busy_c1;

    always #5 clk = ~clk;

    sprite_draw_scheduler dut (
        .clk        (clk),
        .reset      (reset),
        .frame_tick (frame_tick),
        .spr_en     (spr_en),
        .spr_x      (spr_x),
        .spr_y      (spr_y),
        .spr_c      (spr_c),
        .x          (x),
        .y          (y),
        .colour     (colour),
        .plot       (plot),
        .busy       (busy),
        .frame_done (frame_done),
        .overrun    (overrun)
    );

    task automatic set_spr(input int i, input int sx, input int sy, input int c);
        spr_x[8*i +: 8] = 8'(sx);
        spr_y[7*i +: 7] = 7'(sy);
        spr_c[3*i +: 3] = 3'(c);
    endtask

    // Issues one tick and records every plot with its cycle number; cycle 0 is the tick cycle.
    task automatic run_frame(input int extra_at, input int chg_at, input int limit);
        px_q.delete();
        py_q.delete();
        pc_q.delete();
        pt_q.delete();
        done_cyc   = -1;
        done_cnt   = 0;
        busy_after = 1'b1;
        busy_c1    = 1'b0;
        @(negedge clk);
        frame_tick = 1'b1;
        @(posedge clk);
        #1;
        frame_tick = 1'b0;
        for (int cyc = 1; cyc <= limit; cyc++) begin
            if (plot) begin
                px_q.push_back(int'(x));
                py_q.push_back(int'(y));
                pc_q.push_back(int'(colour));
                pt_q.push_back(cyc);
            end
            if (frame_done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (cyc == 1) busy_c1 = busy;
            if (done_cyc >= 0 && cyc == done_cyc + 1) busy_after = busy;
            if (cyc == chg_at) spr_x[7:0] = 8'd77;
            frame_tick = (cyc == extra_at);
            if (done_cyc >= 0 && cyc >= done_cyc + 3) break;
            @(posedge clk);
            #1;
        end
        frame_tick = 1'b0;
    endtask

    task automatic test_reset;
        reset      = 1'b1;
        frame_tick = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({x, y, colour, plot, busy, frame_done, overrun} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: got x=%0d y=%0d c=%0d plot=%b busy=%b done=%b ovr=%b, want all 0",
                     x, y, colour, plot, busy, frame_done, overrun);
        end
        reset      = 1'b0;
        frame_tick = 1'b0;
        @(posedge clk);
        #1;
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_priority: busy=%b, want 0", busy);
        end
    endtask

    task automatic test_clear_only;
        int errs;
        spr_en = '0;
        run_frame(-1, -1, 20000);
        n_cmp++;
        if (px_q.size() != 19200) begin
            n_bad++;
            $display("FAIL clear_count: got %0d plots, want 19200", px_q.size());
        end
        errs = 0;
        foreach (px_q[i])
            if (px_q[i] != i % 160 || py_q[i] != i / 160 || pc_q[i] != 0 || pt_q[i] != i + 2) errs++;
        n_cmp++;
        if (errs != 0) begin
            n_bad++;
            $display("FAIL clear_order: %0d bad sweep pixels, want 0", errs);
        end
        n_cmp++;
        if (done_cyc != 19211) begin
            n_bad++;
            $display("FAIL clear_done_cycle: got %0d, want 19211", done_cyc);
        end
        n_cmp++;
        if (done_cnt != 1) begin
            n_bad++;
            $display("FAIL clear_done_count: got %0d, want 1", done_cnt);
        end
        n_cmp++;
        if (busy_c1 !== 1'b1 || busy_after !== 1'b0) begin
            n_bad++;
            $display("FAIL clear_busy: first=%b after_done=%b, want 1 and 0", busy_c1, busy_after);
        end
        n_cmp++;
        if (overrun !== 1'b0) begin
            n_bad++;
            $display("FAIL clear_overrun: got %b, want 0", overrun);
        end
    endtask

    task automatic test_sprites_clip;
        int errs;
        int ex[4] = '{158, 159, 158, 159};
        int ey[4] = '{118, 118, 119, 119};
        set_spr(0, 10, 20, 4);
        set_spr(8, 158, 118, 2);
        spr_en = 9'b100000001;
        run_frame(-1, -1, 20000);
        n_cmp++;
        if (px_q.size() != 19220) begin
            n_bad++;
            $display("FAIL sprite_count: got %0d plots, want 19220", px_q.size());
        end else begin
            errs = 0;
            for (int i = 0; i < 16; i++)
                if (px_q[19200+i] != 10 + i % 4 || py_q[19200+i] != 20 + i / 4 || pc_q[19200+i] != 4) errs++;
            n_cmp++;
            if (errs != 0) begin
                n_bad++;
                $display("FAIL sprite0_pixels: %0d wrong, want 0", errs);
            end
            n_cmp++;
            if (pt_q[19200] != 19203) begin
                n_bad++;
                $display("FAIL sprite0_first_cycle: got %0d, want 19203", pt_q[19200]);
            end
            errs = 0;
            for (int i = 0; i < 4; i++)
                if (px_q[19216+i] != ex[i] || py_q[19216+i] != ey[i] || pc_q[19216+i] != 2) errs++;
            n_cmp++;
            if (errs != 0) begin
                n_bad++;
                $display("FAIL clip_pixels: %0d wrong, want 0", errs);
            end
        end
        n_cmp++;
        if (done_cyc != 19243) begin
            n_bad++;
            $display("FAIL sprite_done_cycle: got %0d, want 19243", done_cyc);
        end
    endtask

    task automatic test_back_to_back;
        int errs;
        int bx[3] = '{5, 50, 100};
        int by[3] = '{5, 60, 100};
        int bc[3] = '{1, 2, 7};
        for (int i = 0; i < N; i++) set_spr(i, 0, 0, 5);
        set_spr(0, 5, 5, 1);
        set_spr(2, 50, 60, 2);
        set_spr(8, 100, 100, 7);
        spr_en = 9'b100000101;
        n_cmp++;
        if (overrun !== 1'b0) begin
            n_bad++;
            $display("FAIL overrun_before: got %b, want 0", overrun);
        end
        run_frame(500, 19205, 20000);
        n_cmp++;
        if (px_q.size() != 19248) begin
            n_bad++;
            $display("FAIL multi_count: got %0d plots, want 19248", px_q.size());
        end else begin
            errs = 0;
            for (int j = 0; j < 3; j++)
                for (int i = 0; i < 16; i++)
                    if (px_q[19200+16*j+i] != bx[j] + i % 4 || py_q[19200+16*j+i] != by[j] + i / 4 ||
                        pc_q[19200+16*j+i] != bc[j]) errs++;
            n_cmp++;
            if (errs != 0) begin
                n_bad++;
                $display("FAIL multi_order: %0d wrong pixels, want 0", errs);
            end
        end
        n_cmp++;
        if (done_cyc != 19259) begin
            n_bad++;
            $display("FAIL multi_done_cycle: got %0d, want 19259", done_cyc);
        end
        n_cmp++;
        if (done_cnt != 1) begin
            n_bad++;
            $display("FAIL overrun_done_count: got %0d, want 1", done_cnt);
        end
        n_cmp++;
        if (overrun !== 1'b1) begin
            n_bad++;
            $display("FAIL overrun_flag: got %b, want 1", overrun);
        end
    endtask

    task automatic test_reset_mid_draw;
        int cnt;
        set_spr(0, 10, 20, 4);
        spr_en = 9'b000000001;
        @(negedge clk);
        frame_tick = 1'b1;
        @(posedge clk);
        #1;
        frame_tick = 1'b0;
        repeat (19203) @(posedge clk);
        #1;
        n_cmp++;
        if (plot !== 1'b1 || x !== 8'd11 || y !== 7'd20) begin
            n_bad++;
            $display("FAIL middraw_pixel: plot=%b x=%0d y=%0d, want 1 11 20", plot, x, y);
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        n_cmp++;
        if (plot !== 1'b0 || busy !== 1'b0 || overrun !== 1'b0) begin
            n_bad++;
            $display("FAIL middraw_reset: plot=%b busy=%b ovr=%b, want 0 0 0", plot, busy, overrun);
        end
        cnt = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (plot || busy) cnt++;
        end
        n_cmp++;
        if (cnt != 0) begin
            n_bad++;
            $display("FAIL middraw_no_resume: %0d active cycles, want 0", cnt);
        end
        spr_en = '0;
        run_frame(-1, -1, 40);
        n_cmp++;
        if (px_q.size() != 39) begin
            n_bad++;
            $display("FAIL restart_count: got %0d plots, want 39", px_q.size());
        end else begin
            n_cmp++;
            if (px_q[0] != 0 || py_q[0] != 0 || pt_q[0] != 2 || px_q[38] != 38 || py_q[38] != 0) begin
                n_bad++;
                $display("FAIL restart_origin: first (%0d,%0d)@%0d last x=%0d, want (0,0)@2 last x=38",
                         px_q[0], py_q[0], pt_q[0], px_q[38]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_clear_only();
        test_sprites_clip();
        test_back_to_back();
        test_reset_mid_draw();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
